// File: rtl/rice_core_alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Requester 0 is the execute stage and requester 1 is the branch/CSR helper.
// The selected request drives the ALU. The result is captured in a single
// response register, which is drained through a valid/ready port tagged with
// the requester index and an opaque per-request tag.
module rice_core_alu_arbiter #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 4,
    parameter int OP_WIDTH  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic [1:0]             i_req_valid,
    output logic [1:0]             o_req_ready,
    input  logic [2*XLEN-1:0]      i_req_pc,
    input  logic [2*XLEN-1:0]      i_req_rs1_value,
    input  logic [2*XLEN-1:0]      i_req_rs2_value,
    input  logic [2*XLEN-1:0]      i_req_imm_value,
    input  logic [2*OP_WIDTH-1:0]  i_req_operation,
    input  logic [2*TAG_WIDTH-1:0] i_req_tag,
    output logic [XLEN-1:0]        o_alu_pc,
    output logic [XLEN-1:0]        o_alu_rs1_value,
    output logic [XLEN-1:0]        o_alu_rs2_value,
    output logic [XLEN-1:0]        o_alu_imm_value,
    output logic [OP_WIDTH-1:0]    o_alu_operation,
    input  logic [XLEN-1:0]        i_alu_result,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [XLEN-1:0]        o_rsp_result,
    output logic                   o_rsp_id,
    output logic [TAG_WIDTH-1:0]   o_rsp_tag
);

    // Priority pointer: index of the requester that wins a tie.
    logic                 prio_q, prio_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]      rsp_result_q, rsp_result_d;
    logic                 rsp_id_q, rsp_id_d;
    logic [TAG_WIDTH-1:0] rsp_tag_q, rsp_tag_d;

    logic has_winner;
    logic winner;
    logic slot_free;
    logic accept;

    // Round-robin pick: the pointer's requester if valid, else the other one.
    always_comb begin
        has_winner = |i_req_valid;
        winner     = i_req_valid[prio_q] ? prio_q : ~prio_q;
        // The slot may be refilled in the same cycle it drains.
        slot_free  = ~rsp_valid_q | i_rsp_ready;
        accept     = has_winner & slot_free & ~i_flush;
        o_req_ready = 2'b00;
        if (accept) begin
            o_req_ready = winner ? 2'b10 : 2'b01;
        end
    end

    // Steer the winner's payload to the ALU; all zeros when nobody requests.
    always_comb begin
        o_alu_pc        = '0;
        o_alu_rs1_value = '0;
        o_alu_rs2_value = '0;
        o_alu_imm_value = '0;
        o_alu_operation = '0;
        if (has_winner) begin
            if (winner) begin
                o_alu_pc        = i_req_pc[2*XLEN-1:XLEN];
                o_alu_rs1_value = i_req_rs1_value[2*XLEN-1:XLEN];
                o_alu_rs2_value = i_req_rs2_value[2*XLEN-1:XLEN];
                o_alu_imm_value = i_req_imm_value[2*XLEN-1:XLEN];
                o_alu_operation = i_req_operation[2*OP_WIDTH-1:OP_WIDTH];
            end else begin
                o_alu_pc        = i_req_pc[XLEN-1:0];
                o_alu_rs1_value = i_req_rs1_value[XLEN-1:0];
                o_alu_rs2_value = i_req_rs2_value[XLEN-1:0];
                o_alu_imm_value = i_req_imm_value[XLEN-1:0];
                o_alu_operation = i_req_operation[OP_WIDTH-1:0];
            end
        end
    end

    // Next state of the response slot and pointer; flush beats capture and drain.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;
        rsp_tag_d    = rsp_tag_q;
        prio_d       = prio_q;
        if (i_flush) begin
            rsp_valid_d = 1'b0;
        end else if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = i_alu_result;
            rsp_id_d     = winner;
            rsp_tag_d    = winner ? i_req_tag[2*TAG_WIDTH-1:TAG_WIDTH]
                                  : i_req_tag[TAG_WIDTH-1:0];
            prio_d       = ~winner;
        end else if (i_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response register and pointer with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            prio_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= 1'b0;
            rsp_tag_q    <= '0;
        end else begin
            prio_q       <= prio_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_result = rsp_result_q;
    assign o_rsp_id     = rsp_id_q;
    assign o_rsp_tag    = rsp_tag_q;

endmodule
